// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the fetch controller's control inputs and
// status outputs so the controller and its environment share one port.
//   master : environment side (drives start/mode/step/stall/branch/instr_in)
//   slave  : controller side (drives pc_enable/pc_reset/if_flush/status/counters)
interface fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_BITS   = 32
);
    logic                  start;
    logic                  mode;
    logic                  step;
    logic                  stall;
    logic                  branch;
    logic [DATA_WIDTH-1:0] instr_in;
    logic                  pc_enable;
    logic                  pc_reset;
    logic                  if_flush;
    logic                  running;
    logic                  halted;
    logic [CNT_BITS-1:0]   cycle_cnt;
    logic [CNT_BITS-1:0]   fetch_cnt;

    modport master (
        output start, mode, step, stall, branch, instr_in,
        input  pc_enable, pc_reset, if_flush, running, halted, cycle_cnt, fetch_cnt
    );

    modport slave (
        input  start, mode, step, stall, branch, instr_in,
        output pc_enable, pc_reset, if_flush, running, halted, cycle_cnt, fetch_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the instruction-fetch stage.
// Runs fetch continuously or one step at a time, holds off on hazard
// stalls, flushes IF/ID on taken branches, and on a halt word drains the
// pipeline for DRAIN_CYCLES before parking in HALTED.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-low reset
//   bus   - fetch_ctrl_if.slave (start/mode/step/stall/branch/instr_in in;
//           pc_enable/pc_reset/if_flush/running/halted/cycle_cnt/fetch_cnt out)
module fetch_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CNT_BITS     = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD    = {DATA_WIDTH{1'b1}},
    parameter int                    DRAIN_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [2:0]          state, state_nxt;
    logic                step_pending, pend_nxt;
    logic [DCW-1:0]      drain_cnt, drain_nxt;
    logic [CNT_BITS-1:0] cycle_cnt, cyc_nxt;
    logic [CNT_BITS-1:0] fetch_cnt, fet_nxt;

    logic fetching;
    logic halt_hit;
    logic pc_enable;

    assign fetching = (state == S_RUN) || (state == S_STEP);

    // A halt word on a branch cycle is wrong-path; under stall it is not
    // yet the committed fetch, so neither counts as a halt.
    assign halt_hit = fetching && (bus.instr_in == HALT_WORD) && !bus.branch && !bus.stall;

    always_comb begin
        pc_enable = 1'b0;
        case (state)
            S_RUN:  pc_enable = !bus.stall && !halt_hit;
            S_STEP: pc_enable = (bus.step || step_pending) && !bus.stall && !halt_hit;
            default: pc_enable = 1'b0;
        endcase
    end

    assign bus.pc_enable = pc_enable;
    assign bus.pc_reset  = (state == S_IDLE);
    assign bus.if_flush  = bus.branch && fetching;
    assign bus.running   = fetching;
    assign bus.halted    = (state == S_HALTED);
    assign bus.cycle_cnt = cycle_cnt;
    assign bus.fetch_cnt = fetch_cnt;

    always_comb begin
        state_nxt = state;
        pend_nxt  = step_pending;
        drain_nxt = drain_cnt;
        cyc_nxt   = cycle_cnt;
        fet_nxt   = fetch_cnt;

        // Counters saturate; HALTED and IDLE leave them untouched.
        if (state == S_RUN || state == S_STEP || state == S_DRAIN) begin
            if (cycle_cnt != {CNT_BITS{1'b1}}) cyc_nxt = cycle_cnt + 1'b1;
        end
        if (pc_enable && fetch_cnt != {CNT_BITS{1'b1}}) fet_nxt = fetch_cnt + 1'b1;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = bus.mode ? S_STEP : S_RUN;
                    pend_nxt  = 1'b0;
                    cyc_nxt   = '0;
                    fet_nxt   = '0;
                end
            end
            S_RUN: begin
                if (halt_hit) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = DCW'(DRAIN_CYCLES - 1);
                end else if (bus.mode) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                // One step of look-ahead only: a pulse arriving while one is
                // already pending, or on the consuming cycle, is dropped.
                if (pc_enable || halt_hit) pend_nxt = 1'b0;
                else if (bus.step)         pend_nxt = 1'b1;
                if (halt_hit) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = DCW'(DRAIN_CYCLES - 1);
                end else if (!bus.mode) begin
                    state_nxt = S_RUN;
                    pend_nxt  = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nxt = S_HALTED;
                else                 drain_nxt = drain_cnt - 1'b1;
            end
            S_HALTED: begin
                if (bus.start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            step_pending <= 1'b0;
            drain_cnt    <= '0;
            cycle_cnt    <= '0;
            fetch_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            step_pending <= pend_nxt;
            drain_cnt    <= drain_nxt;
            cycle_cnt    <= cyc_nxt;
            fetch_cnt    <= fet_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl. Each vector drives one
// cycle of inputs and queues the hand-computed outputs for that cycle; a
// monitor on the falling edge pops and compares.
module tb_fetch_ctrl;

    localparam logic [31:0] N = 32'h0000_0013;
    localparam logic [31:0] H = 32'hFFFF_FFFF;

    typedef struct {
        string       nm;
        logic        pe, pr, fl, run, hlt;
        logic [31:0] cc, fc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    fetch_ctrl_if #(.DATA_WIDTH(32), .CNT_BITS(32)) bus ();

    fetch_ctrl #(
        .DATA_WIDTH  (32),
        .CNT_BITS    (32),
        .HALT_WORD   (32'hFFFF_FFFF),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            cmp(e.nm, "pc_enable", 32'(bus.pc_enable), 32'(e.pe));
            cmp(e.nm, "pc_reset",  32'(bus.pc_reset),  32'(e.pr));
            cmp(e.nm, "if_flush",  32'(bus.if_flush),  32'(e.fl));
            cmp(e.nm, "running",   32'(bus.running),   32'(e.run));
            cmp(e.nm, "halted",    32'(bus.halted),    32'(e.hlt));
            cmp(e.nm, "cycle_cnt", bus.cycle_cnt, e.cc);
            cmp(e.nm, "fetch_cnt", bus.fetch_cnt, e.fc);
        end
    end

    task automatic vec(input string nm, input logic rn, st, md, sp, sl, br, input logic [31:0] ins,
                       input logic epe, epr, efl, erun, ehlt, input int ecc, efc);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rn;
        bus.start    = st;
        bus.mode     = md;
        bus.step     = sp;
        bus.stall    = sl;
        bus.branch   = br;
        bus.instr_in = ins;
        e.nm = nm; e.pe = epe; e.pr = epr; e.fl = efl; e.run = erun; e.hlt = ehlt;
        e.cc = 32'(ecc); e.fc = 32'(efc);
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 0; bus.mode = 0; bus.step = 0; bus.stall = 0; bus.branch = 0; bus.instr_in = N;
        repeat (2) @(posedge clk);

        // reset state, continuous run, async reset mid-run
        vec("rst_idle",   0,0,0,0,0,0,N, 0,1,0,0,0, 0,0);
        vec("start_run",  1,1,0,0,0,0,N, 0,1,0,0,0, 0,0);
        for (int i = 1; i <= 10; i++)
            vec("run_fetch", 1,0,0,0,0,0,N, 1,0,0,1,0, i-1,i-1);
        vec("run_cnt10",  1,0,0,0,0,0,N, 1,0,0,1,0, 10,10);
        vec("async_rst",  0,0,0,0,0,0,N, 0,1,0,0,0, 0,0);

        // stall hold-off
        vec("start_b",    1,1,0,0,0,0,N, 0,1,0,0,0, 0,0);
        vec("stall_pre",  1,0,0,0,0,0,N, 1,0,0,1,0, 0,0);
        for (int i = 0; i < 3; i++)
            vec("stall_hold", 1,0,0,0,1,0,N, 0,0,0,1,0, 1+i,1);
        vec("stall_rel",  1,0,0,0,0,0,N, 1,0,0,1,0, 4,1);
        vec("stall_lag",  1,0,0,0,0,0,N, 1,0,0,1,0, 5,2);

        // halt at cycle 5, drain 4, halted at 10, start returns to IDLE
        vec("rst_c",      0,0,0,0,0,0,N, 0,1,0,0,0, 0,0);
        vec("start_c",    1,1,0,0,0,0,N, 0,1,0,0,0, 0,0);
        for (int i = 1; i <= 4; i++)
            vec("halt_pre", 1,0,0,0,0,0,N, 1,0,0,1,0, i-1,i-1);
        vec("halt_hit",   1,0,0,0,0,0,H, 0,0,0,1,0, 4,4);
        for (int i = 0; i < 4; i++)
            vec("drain",    1,0,0,0,0,0,N, 0,0,0,0,0, 5+i,4);
        vec("halted",     1,1,0,0,0,0,N, 0,0,0,0,1, 9,4);
        vec("halt_idle",  1,0,0,0,0,0,N, 0,1,0,0,0, 9,4);

        // halt word on branch / under stall is ignored; start in RUN ignored
        vec("start_d",    1,1,0,0,0,0,N, 0,1,0,0,0, 9,4);
        vec("run_d",      1,0,0,0,0,0,N, 1,0,0,1,0, 0,0);
        vec("halt_branch",1,0,0,0,0,1,H, 1,0,1,1,0, 1,1);
        vec("start_ign",  1,1,0,0,0,0,N, 1,0,0,1,0, 2,2);
        vec("halt_stall", 1,0,0,0,1,0,H, 0,0,0,1,0, 3,3);
        vec("run_cont",   1,0,0,0,0,0,N, 1,0,0,1,0, 4,3);

        // single step, two pulses during a stall yield one fetch
        vec("rst_e",      0,0,0,0,0,0,N, 0,1,0,0,0, 0,0);
        vec("start_step", 1,1,1,0,0,0,N, 0,1,0,0,0, 0,0);
        vec("step_idle",  1,0,1,0,0,0,N, 0,0,0,1,0, 0,0);
        vec("step_stall1",1,0,1,1,1,0,N, 0,0,0,1,0, 1,0);
        vec("step_stall2",1,0,1,1,1,0,N, 0,0,0,1,0, 2,0);
        vec("step_pend",  1,0,1,0,0,0,N, 1,0,0,1,0, 3,0);
        vec("step_once",  1,0,1,0,0,0,N, 0,0,0,1,0, 4,1);
        vec("step_direct",1,0,1,1,0,0,N, 1,0,0,1,0, 5,1);
        vec("step_done",  1,0,1,0,0,0,N, 0,0,0,1,0, 6,2);
        vec("step_branch",1,0,1,0,0,1,N, 0,0,1,1,0, 7,2);

        // mode switches STEP->RUN->STEP, then halt from step mode
        vec("to_run",     1,0,0,0,0,0,N, 0,0,0,1,0, 8,2);
        vec("run_f",      1,0,0,0,0,0,N, 1,0,0,1,0, 9,2);
        vec("to_step",    1,0,1,0,0,0,N, 1,0,0,1,0, 10,3);
        vec("step_wait1", 1,0,1,0,0,0,N, 0,0,0,1,0, 11,4);
        vec("step_wait2", 1,0,1,0,0,0,N, 0,0,0,1,0, 12,4);
        vec("step_go",    1,0,1,1,0,0,N, 1,0,0,1,0, 13,4);
        vec("step_after", 1,0,1,0,0,0,N, 0,0,0,1,0, 14,5);
        vec("step_halt",  1,0,1,1,0,0,H, 0,0,0,1,0, 15,5);
        vec("step_drain", 1,0,1,0,0,0,N, 0,0,0,0,0, 16,5);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Drives the fetch stage's PC enable and PC reset, and flushes the IF/ID register on a taken branch. Supports continuous run, single-step execution, stall hold-off from the hazard unit, and halt detection with pipeline drain. It also keeps cycle and fetch counters for the debug unit.

## Interface
- DATA_WIDTH, 32, width of the fetched instruction word
- CNT_BITS, 32, width of cycle_cnt and fetch_cnt
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- DRAIN_CYCLES, 4, cycles spent in DRAIN after a halt hit so in-flight instructions retire (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  one-cycle pulse; IDLE→run, HALTED→IDLE
- mode  in  1  0 = continuous run, 1 = single step
- step  in  1  one-cycle pulse; requests one fetch in step mode
- stall  in  1  hazard unit hold; blocks pc_enable while high
- branch  in  1  taken branch this cycle
- instr_in  in  DATA_WIDTH  word currently presented by the fetch stage
- pc_enable  out  1  PC/instruction-memory advance enable
- pc_reset  out  1  active-high PC clear to fetch stage
- if_flush  out  1  clear IF/ID register
- running  out  1  state is RUN or STEP_WAIT
- halted  out  1  state is HALTED
- cycle_cnt  out  CNT_BITS  active cycles since last start
- fetch_cnt  out  CNT_BITS  cycles with pc_enable=1 since last start

## Operation
- States: IDLE, RUN, STEP_WAIT, DRAIN, HALTED. Reset enters IDLE.
- halt_hit = (instr_in == HALT_WORD) & ~branch & ~stall, evaluated in RUN and STEP_WAIT only.
  - A halt word coinciding with branch is wrong-path and is ignored.
- IDLE
  - Outputs: pc_reset=1, pc_enable=0.
  - start: go to RUN if mode=0, else STEP_WAIT. Clear both counters and step_pending.
- RUN
  - pc_enable = ~stall & ~halt_hit.
  - halt_hit → DRAIN.
  - Otherwise mode=1 → STEP_WAIT.
- STEP_WAIT
  - step_pending is set by a step pulse, including one arriving during stall.
  - pc_enable = (step | step_pending) & ~stall & ~halt_hit.
  - step_pending clears on the cycle pc_enable=1.
  - Extra step pulses while step_pending=1 are discarded; no queueing beyond one.
  - halt_hit → DRAIN, and step_pending clears.
  - Otherwise mode=0 → RUN; a pending step is dropped.
- DRAIN
  - pc_enable=0.
  - Down-counter loaded with DRAIN_CYCLES−1 on entry; at 0 → HALTED.
- HALTED
  - pc_enable=0, halted=1.
  - start → IDLE; a second start is then required to run.
- if_flush = branch & (state RUN or STEP_WAIT). It is independent of stall.
- Counters
  - cycle_cnt increments each cycle in RUN, STEP_WAIT or DRAIN.
  - fetch_cnt increments each cycle pc_enable=1.
  - Both saturate at all-ones and hold in HALTED.
- start in RUN, STEP_WAIT or DRAIN is ignored.

## Timing
- Reset values: state IDLE, pc_reset=1, pc_enable=0, if_flush=0, running=0, halted=0, cycle_cnt=0, fetch_cnt=0, step_pending=0.
- pc_enable and if_flush are combinational from state and the current-cycle stall, step, branch and instr_in.
- The halt word never causes a PC advance, so the PC remains on the halt address.
- start→RUN takes one edge: pc_reset drops and pc_enable can rise the cycle after start.
- Single step gives exactly one pc_enable cycle per accepted step.
- Halt hit at cycle N puts the block in DRAIN for cycles N+1…N+DRAIN_CYCLES; halted=1 from cycle N+DRAIN_CYCLES+1.
- Reset assertion mid-operation forces IDLE outputs asynchronously, without waiting for a clock edge.

## Test plan
- Reset, then start with mode=0 and 10 non-halt words: pc_enable high from cycle 1, fetch_cnt=10 and cycle_cnt=10 after 10 cycles. Assert reset mid-run: pc_reset=1 and counters 0 immediately.
- Run with stall high for 3 cycles: pc_enable=0 for exactly those 3 cycles, and fetch_cnt lags cycle_cnt by 3.
- HALT_WORD at cycle 5 with DRAIN_CYCLES=4: pc_enable=0 at cycle 5, halted=1 at cycle 10, then start → IDLE with pc_reset=1.
- HALT_WORD together with branch=1: no halt, if_flush=1, run continues.
- Step mode, step pulse while stall=1 for 2 cycles: pc_enable=1 for one cycle after stall drops. Two step pulses during the stall give only one fetch.
- Switch mode 0→1 in RUN: next state STEP_WAIT, pc_enable=0 until the next step pulse.
